// File: rtl/demux_route9_pkg.sv
// Shared constants, state encoding and select-legality helper for the 1-to-9 router.
package demux_route9_pkg;

  localparam int NUM_DEST = 9;
  localparam int SEL_W    = 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef logic [NUM_DEST-1:0] onehot_t;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel < SEL_W'(NUM_DEST);
  endfunction

endpackage

// File: rtl/sel_dec_4to9.sv
// Combinational destination decoder: 4-bit code to 9-bit one-hot, all-zero for codes 9..15.
module sel_dec_4to9
  import demux_route9_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output onehot_t          onehot,
  output logic             legal
);

  always_comb begin
    legal  = sel_legal(sel);
    onehot = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      onehot[k] = legal && (sel == SEL_W'(k));
    end
  end

endmodule

// File: rtl/demux_route9.sv
// Registered 1-to-9 router with a 2-entry in-order buffer (output reg + skid reg)
// and a saturating counter for words dropped on illegal destination codes.
//
//   state | meaning
//   ------+--------------------------------------------------
//   EMPTY | nothing held, out_valid = 0
//   ONE   | output reg holds the head word
//   TWO   | output reg and skid reg both full, in_ready = 0
module demux_route9
  import demux_route9_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_W-1:0]    in_sel,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                err_flag
);

  logic [1:0]       state;
  onehot_t          out_oh;
  onehot_t          skid_oh;
  onehot_t          dec_oh;
  logic [WIDTH-1:0] out_dat;
  logic [WIDTH-1:0] skid_dat;
  logic             dec_legal;
  logic             accept;
  logic             push;
  logic             drop;
  logic             complete;
  logic [CNT_W-1:0] err_q;
  logic             flag_q;

  sel_dec_4to9 u_sel_dec (
    .sel    (in_sel),
    .onehot (dec_oh),
    .legal  (dec_legal)
  );

  // Gating with reset keeps the producer stalled while the buffer is being cleared.
  assign in_ready = ~reset & (state != ST_TWO);
  assign accept   = in_valid & in_ready;
  assign push     = accept & dec_legal;
  assign drop     = accept & ~dec_legal;
  assign complete = |(out_oh & out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      out_oh   <= '0;
      out_dat  <= '0;
      skid_oh  <= '0;
      skid_dat <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state   <= ST_ONE;
            out_oh  <= dec_oh;
            out_dat <= in_data;
          end
        end
        ST_ONE: begin
          if (complete && push) begin
            out_oh  <= dec_oh;
            out_dat <= in_data;
          end else if (complete) begin
            state  <= ST_EMPTY;
            out_oh <= '0;
          end else if (push) begin
            state    <= ST_TWO;
            skid_oh  <= dec_oh;
            skid_dat <= in_data;
          end
        end
        ST_TWO: begin
          if (complete) begin
            state   <= ST_ONE;
            out_oh  <= skid_oh;
            out_dat <= skid_dat;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          out_oh <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q  <= '0;
      flag_q <= 1'b0;
    end else if (drop) begin
      flag_q <= 1'b1;
      if (err_q != '1) begin
        err_q <= err_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_oh;
  assign out_data  = out_dat;
  assign err_cnt   = err_q;
  assign err_flag  = flag_q;

endmodule

// File: tb/tb_demux_route9.sv
// Bench for demux_route9: a queue-based reference of the in-order router checked
// every cycle, plus directed scenarios with literal expected values.
module tb_demux_route9;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_sel;
  logic [8:0]  out_valid;
  logic [8:0]  out_ready;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;
  logic        err_flag;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_done = 0;

  demux_route9 #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_cnt   (err_cnt),
    .err_flag  (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two accepted legal words; the head is what the
  // outputs show, and it leaves when its own destination is ready.
  typedef struct {
    int          dest;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_last;
  int          m_err;
  bit          m_flag;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_last = '0;
      m_err  = 0;
      m_flag = 0;
    end else begin
      bit rdy;
      rdy = (mq.size() < 2);
      if (mq.size() > 0 && out_ready[mq[0].dest]) void'(mq.pop_front());
      if (in_valid && rdy) begin
        if (in_sel <= 4'd8) begin
          ent_t e;
          e.dest = int'(in_sel);
          e.data = in_data;
          mq.push_back(e);
        end else begin
          m_flag = 1;
          if (m_err < 255) m_err++;
        end
      end
      if (mq.size() > 0) m_last = mq[0].data;
    end
  end

  always @(negedge clk) begin
    logic [8:0]  ev;
    logic [31:0] ed;
    ev = '0;
    ed = m_last;
    if (mq.size() > 0) begin
      ev = 9'(1) << mq[0].dest;
      ed = mq[0].data;
    end
    chk("mdl_out_valid", out_valid, ev);
    chk("mdl_out_data", out_data, ed);
    chk("mdl_in_ready", in_ready, (!reset && mq.size() < 2));
    chk("mdl_err_cnt", err_cnt, m_err);
    chk("mdl_err_flag", err_flag, m_flag);
    if (!reset && (out_valid & out_ready) != 0) n_done++;
  end

  always @(posedge clk) cyc++;

  // Called at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic push(input logic [3:0] sel, input logic [31:0] data);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int d0;
    int c0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '1;
    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready_rel", in_ready, 1);

    // single word
    push(4'd3, 32'hDEADBEEF);
    chk("single_valid", out_valid, 9'h008);
    chk("single_data", out_data, 32'hDEADBEEF);
    step(1);
    chk("single_drained", out_valid, 9'h000);
    chk("single_data_hold", out_data, 32'hDEADBEEF);
    chk("single_ready", in_ready, 1);

    // backpressure and ordering
    out_ready = '0;
    push(4'd0, 32'hAAAA0000);
    push(4'd8, 32'hBBBB0008);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_valid", out_valid, 9'h001);
    chk("bp_head_data", out_data, 32'hAAAA0000);
    out_ready = 9'h001;
    step(1);
    chk("bp_second_valid", out_valid, 9'h100);
    chk("bp_second_data", out_data, 32'hBBBB0008);
    chk("bp_in_ready_back", in_ready, 1);
    out_ready = '1;
    step(1);
    chk("bp_empty", out_valid, 9'h000);

    // ready only on other channels
    out_ready = 9'h1DF;
    push(4'd5, 32'h55555555);
    for (int i = 0; i < 10; i++) begin
      chk("wrong_ch_valid", out_valid, 9'h020);
      chk("wrong_ch_data", out_data, 32'h55555555);
      step(1);
    end
    out_ready = '1;
    step(1);
    chk("wrong_ch_drained", out_valid, 9'h000);

    // illegal selects
    push(4'd9, 32'h9);
    push(4'd12, 32'hC);
    push(4'd15, 32'hF);
    step(1);
    chk("illegal_valid", out_valid, 9'h000);
    chk("illegal_cnt3", err_cnt, 8'd3);
    chk("illegal_flag", err_flag, 1);
    for (int i = 0; i < 300; i++) push(4'(9 + (i % 7)), 32'(i));
    step(1);
    chk("illegal_sat", err_cnt, 8'd255);
    chk("illegal_flag_hold", err_flag, 1);

    // streaming at one word per cycle
    d0 = n_done;
    c0 = cyc;
    for (int i = 0; i < 1000; i++) push(4'($urandom_range(0, 8)), $urandom);
    chk("stream_cycles", cyc - c0, 1000);
    step(2);
    chk("stream_delivered", n_done - d0, 1000);
    chk("stream_empty", out_valid, 9'h000);

    // async reset while full
    out_ready = '0;
    push(4'd1, 32'h11111111);
    push(4'd2, 32'h22222222);
    chk("full_before_rst", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 9'h000);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_err_flag", err_flag, 0);
    #1;
    step(2);
    reset = 1'b0;
    out_ready = '1;
    push(4'd6, 32'h66666666);
    chk("post_rst_valid", out_valid, 9'h040);
    chk("post_rst_data", out_data, 32'h66666666);
    step(1);
    chk("post_rst_alone", out_valid, 9'h000);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
